// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the PC stage and decode: reset vector, redirect kinds, FSM states.
package pc_fetch_unit_pkg;

  localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_3000;

  typedef enum logic [1:0] {
    RK_BRANCH = 2'b00,
    RK_JUMP   = 2'b01,
    RK_REG    = 2'b10,
    RK_RSVD   = 2'b11
  } redirect_kind_t;

  typedef enum logic [1:0] {
    ST_BOOT = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } state_t;

  // Signed word offset turned into a byte offset.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/pc_fetch_unit_target_calc.sv
// Combinational next-PC candidates: sequential PC and the redirect target for a given kind.
module pc_target_calc
  import pc_fetch_unit_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [1:0]  kind,
  input  logic [15:0] imm,
  input  logic [25:0] jump_target,
  input  logic [31:0] reg_target,
  output logic [31:0] pc_plus4,
  output logic [31:0] target,
  output logic        take,
  output logic        align_err
);

  // Target selection; the reserved kind yields no redirect.
  always_comb begin
    pc_plus4  = pc + 32'd4;
    target    = pc;
    take      = 1'b0;
    align_err = 1'b0;
    case (redirect_kind_t'(kind))
      RK_BRANCH: begin
        target = pc_plus4 + branch_offset(imm);
        take   = 1'b1;
      end
      RK_JUMP: begin
        target = {pc_plus4[31:28], jump_target, 2'b00};
        take   = 1'b1;
      end
      RK_REG: begin
        target    = reg_target;
        take      = 1'b1;
        align_err = |reg_target[1:0];
      end
      default: begin
        take = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program-counter stage: PC register, BOOT/RUN/HALT control, redirect/stall/handshake priority.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        fetch_ready,
  input  logic        redirect_valid,
  input  logic [1:0]  redirect_kind,
  input  logic [15:0] branch_imm,
  input  logic [25:0] jump_target,
  input  logic [31:0] reg_target,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_valid,
  output logic        misaligned
);

  state_t      state;
  logic [31:0] target;
  logic        take;
  logic        align_err;

  pc_target_calc u_target_calc (
    .pc          (pc),
    .kind        (redirect_kind),
    .imm         (branch_imm),
    .jump_target (jump_target),
    .reg_target  (reg_target),
    .pc_plus4    (pc_plus4),
    .target      (target),
    .take        (take),
    .align_err   (align_err)
  );

  // State, PC and registered status flags; redirect beats stall beats handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_BOOT;
      pc          <= RESET_VECTOR;
      fetch_valid <= 1'b0;
      misaligned  <= 1'b0;
    end else begin
      case (state)
        ST_BOOT: begin
          state       <= ST_RUN;
          fetch_valid <= 1'b1;
        end
        ST_RUN: begin
          if (redirect_valid && take) begin
            if (align_err) begin
              state       <= ST_HALT;
              fetch_valid <= 1'b0;
              misaligned  <= 1'b1;
            end else begin
              pc <= target;
            end
          end else if (!stall && fetch_valid && fetch_ready) begin
            pc <= pc_plus4;
          end
        end
        ST_HALT: begin
          fetch_valid <= 1'b0;
        end
        default: begin
          state       <= ST_HALT;
          fetch_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed scenarios followed by random traffic against a behavioural model.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        fetch_ready;
  logic        redirect_valid;
  logic [1:0]  redirect_kind;
  logic [15:0] branch_imm;
  logic [25:0] jump_target;
  logic [31:0] reg_target;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_valid;
  logic        misaligned;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  localparam int M_BOOT = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;
  localparam logic [31:0] RV = 32'h0000_3000;

  int          m_mode = M_BOOT;
  logic [31:0] m_pc   = RV;
  logic        m_mis  = 1'b0;

  pc_fetch_unit #(.RESET_VECTOR(RV)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .fetch_ready    (fetch_ready),
    .redirect_valid (redirect_valid),
    .redirect_kind  (redirect_kind),
    .branch_imm     (branch_imm),
    .jump_target    (jump_target),
    .reg_target     (reg_target),
    .pc             (pc),
    .pc_plus4       (pc_plus4),
    .fetch_valid    (fetch_valid),
    .misaligned     (misaligned)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Predict the next architectural state from the rules, clock once, compare.
  task automatic step();
    int          n_mode = m_mode;
    logic [31:0] n_pc   = m_pc;
    logic        n_mis  = m_mis;
    longint      off;
    if (rst) begin
      n_mode = M_BOOT;
      n_pc   = RV;
      n_mis  = 1'b0;
    end else if (m_mode == M_BOOT) begin
      n_mode = M_RUN;
    end else if (m_mode == M_RUN) begin
      if (redirect_valid && redirect_kind != 2'd3) begin
        if (redirect_kind == 2'd0) begin
          off  = longint'($signed(branch_imm)) * 4;
          n_pc = 32'(longint'(m_pc) + 4 + off);
        end else if (redirect_kind == 2'd1) begin
          n_pc = ((m_pc + 32'd4) & 32'hF000_0000) | (32'(jump_target) * 32'd4);
        end else if (reg_target % 4 != 0) begin
          n_mode = M_HALT;
          n_mis  = 1'b1;
        end else begin
          n_pc = reg_target;
        end
      end else if (!stall && fetch_ready) begin
        n_pc = m_pc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
    m_mode = n_mode;
    m_pc   = n_pc;
    m_mis  = n_mis;
    check_eq("pc", pc, m_pc);
    check_eq("pc_plus4", pc_plus4, m_pc + 32'd4);
    check_eq("fetch_valid", 32'(fetch_valid), 32'(m_mode == M_RUN));
    check_eq("misaligned", 32'(misaligned), 32'(m_mis));
  endtask

  task automatic idle_inputs();
    rst = 1'b0; stall = 1'b0; fetch_ready = 1'b0; redirect_valid = 1'b0;
    redirect_kind = 2'd0; branch_imm = '0; jump_target = '0; reg_target = '0;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    step(); step();
    check_eq("t1_boot_fv", 32'(fetch_valid), 32'd0);
    check_eq("t1_boot_pc", pc, 32'h0000_3000);
    rst = 1'b0;
    step();
    check_eq("t1_run_fv", 32'(fetch_valid), 32'd1);

    fetch_ready = 1'b1;
    step(); step(); step();
    check_eq("t2_pc", pc, 32'h0000_300C);
    fetch_ready = 1'b0;
    step(); step();
    check_eq("t2_hold", pc, 32'h0000_300C);
    fetch_ready = 1'b1;
    step();
    check_eq("t3_start", pc, 32'h0000_3010);

    stall = 1'b1; redirect_valid = 1'b1; redirect_kind = 2'd0; branch_imm = 16'hFFFC;
    step();
    check_eq("t3_branch", pc, 32'h0000_3004);
    stall = 1'b0; redirect_kind = 2'd1; jump_target = 26'h100;
    step();
    check_eq("t4_jump", pc, 32'h0000_0400);
    redirect_kind = 2'd3;
    step();
    check_eq("t4_rsvd", pc, 32'h0000_0404);

    redirect_kind = 2'd2; reg_target = 32'h0000_3002;
    step();
    check_eq("t5_mis", 32'(misaligned), 32'd1);
    check_eq("t5_pc", pc, 32'h0000_0404);
    redirect_kind = 2'd1;
    step(); step();
    check_eq("t5_frozen", pc, 32'h0000_0404);
    redirect_valid = 1'b0; rst = 1'b1;
    step();
    check_eq("t5_rst_pc", pc, 32'h0000_3000);
    check_eq("t5_rst_mis", 32'(misaligned), 32'd0);
    rst = 1'b0;
    step();

    redirect_valid = 1'b1; redirect_kind = 2'd2; reg_target = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0; fetch_ready = 1'b1;
    step();
    check_eq("t6_wrap", pc, 32'h0000_0000);
    stall = 1'b1;
    step();
    rst = 1'b1;
    step();
    check_eq("t6_rst_stall", pc, 32'h0000_3000);
    rst = 1'b0; stall = 1'b0;
    step();

    // Branch wrapping below address zero.
    redirect_valid = 1'b1; redirect_kind = 2'd2; reg_target = 32'h0000_0004;
    step();
    redirect_kind = 2'd0; branch_imm = 16'hFFF0;
    step();
    check_eq("branch_wrap", pc, 32'hFFFF_FFC8);

    for (int unsigned i = 0; i < 600; i++) begin
      rst            = ($urandom_range(0, 39) == 0) || (m_mode == M_HALT && $urandom_range(0, 5) == 0);
      stall          = ($urandom_range(0, 3) == 0);
      fetch_ready    = ($urandom_range(0, 2) != 0);
      redirect_valid = ($urandom_range(0, 3) == 0);
      redirect_kind  = 2'($urandom_range(0, 3));
      branch_imm     = 16'($urandom);
      jump_target    = 26'($urandom);
      reg_target     = $urandom;
      if ($urandom_range(0, 7) != 0) reg_target[1:0] = 2'b00;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
